// File: rtl/writeback_regfile.sv
// Y86-64 SEQ write-back stage and 15 x XLEN architectural register file.
// Define WB_BYPASS_EN to forward in-flight write data onto the read ports.
module writeback_regfile #(
   parameter int XLEN    = 64,
   parameter int NREG    = 15,
   parameter int RSP_IDX = 4,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wb_en,
   input  logic [3:0]       icode,
   input  logic             cnd,
   input  logic [3:0]       rA,
   input  logic [3:0]       rB,
   input  logic [XLEN-1:0]  valE,
   input  logic [XLEN-1:0]  valM,
   input  logic [3:0]       srcA,
   input  logic [3:0]       srcB,
   output logic [XLEN-1:0]  valA,
   output logic [XLEN-1:0]  valB,
   output logic [3:0]       dstE,
   output logic [3:0]       dstM,
   output logic [1:0]       stat,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [1:0] {
      ST_AOK = 2'd0,
      ST_HLT = 2'd1,
      ST_INS = 2'd2
   } stat_e;

   localparam logic [3:0] R_NONE = 4'hF;
   localparam logic [3:0] R_RSP  = 4'(RSP_IDX);

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_RRMOV  = 4'h2;
   localparam logic [3:0] I_IRMOV  = 4'h3;
   localparam logic [3:0] I_MRMOV  = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSH   = 4'hA;
   localparam logic [3:0] I_POP    = 4'hB;

   logic [XLEN-1:0]  regs_q [NREG];
   logic [XLEN-1:0]  regs_d [NREG];
   stat_e            stat_q, stat_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic commit;
   logic legal;
   logic we_e;
   logic we_m;

   always_comb begin
      dstE = R_NONE;
      case (icode)
         I_RRMOV: dstE = cnd ? rB : R_NONE;
         I_IRMOV,
         I_OPQ:   dstE = rB;
         I_CALL,
         I_RET,
         I_PUSH,
         I_POP:   dstE = R_RSP;
         default: dstE = R_NONE;
      endcase
   end

   always_comb begin
      dstM = R_NONE;
      case (icode)
         I_MRMOV,
         I_POP:   dstM = rA;
         default: dstM = R_NONE;
      endcase
   end

   assign commit = wb_en && (stat_q == ST_AOK);
   assign legal  = (icode <= I_POP);
   assign we_e   = commit && legal && (dstE != R_NONE);
   assign we_m   = commit && legal && (dstM != R_NONE);

   // dstM is applied last so popq %rsp keeps the popped value.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         regs_d[i] = regs_q[i];
         if (we_e && dstE == 4'(i))
            regs_d[i] = valE;
         if (we_m && dstM == 4'(i))
            regs_d[i] = valM;
      end
   end

   always_comb begin
      stat_d    = stat_q;
      retired_d = retired_q;
      if (commit) begin
         if (!legal) begin
            stat_d = ST_INS;
         end else begin
            retired_d = retired_q + 1'b1;
            if (icode == I_HALT)
               stat_d = ST_HLT;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            regs_q[i] <= '0;
         stat_q    <= ST_AOK;
         retired_q <= '0;
      end else begin
         for (int i = 0; i < NREG; i++)
            regs_q[i] <= regs_d[i];
         stat_q    <= stat_d;
         retired_q <= retired_d;
      end
   end

   function automatic logic [XLEN-1:0] rd_port(input logic [3:0] src);
      logic [XLEN-1:0] v;
      v = '0;
      if (src != R_NONE) begin
         v = regs_q[src];
`ifdef WB_BYPASS_EN
         if (we_m && src == dstM)
            v = valM;
         else if (we_e && src == dstE)
            v = valE;
`endif
      end
      return v;
   endfunction

   assign valA    = rd_port(srcA);
   assign valB    = rd_port(srcB);
   assign stat    = stat_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: decode table, directed corner sequences,
// then randomized traffic against an array-based architectural model.
module tb_writeback_regfile;

   logic        clk;
   logic        rst;
   logic        wb_en;
   logic [3:0]  icode;
   logic        cnd;
   logic [3:0]  rA, rB;
   logic [63:0] valE, valM;
   logic [3:0]  srcA, srcB;
   logic [63:0] valA, valB;
   logic [3:0]  dstE, dstM;
   logic [1:0]  stat;
   logic [31:0] retired;

   int nvec;
   int nerr;

   logic [63:0] m_regs [15];
   int          m_stat;
   logic [31:0] m_ret;

   writeback_regfile dut (
      .clk     (clk),
      .rst     (rst),
      .wb_en   (wb_en),
      .icode   (icode),
      .cnd     (cnd),
      .rA      (rA),
      .rB      (rB),
      .valE    (valE),
      .valM    (valM),
      .srcA    (srcA),
      .srcB    (srcB),
      .valA    (valA),
      .valB    (valB),
      .dstE    (dstE),
      .dstM    (dstM),
      .stat    (stat),
      .retired (retired)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [3:0] ref_dstE(input logic [3:0] ic,
                                           input logic c,
                                           input logic [3:0] b);
      if (ic == 2) return c ? b : 4'hF;
      if (ic == 3 || ic == 6) return b;
      if (ic >= 8 && ic <= 11) return 4'd4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] ref_dstM(input logic [3:0] ic,
                                           input logic [3:0] a);
      if (ic == 5 || ic == 11) return a;
      return 4'hF;
   endfunction

   function automatic logic [63:0] ref_read(input logic [3:0] s);
      logic [3:0] de, dm;
      logic       com;
      if (s == 4'hF) return 64'd0;
      de  = ref_dstE(icode, cnd, rB);
      dm  = ref_dstM(icode, rA);
      com = wb_en && m_stat == 0 && icode <= 11;
`ifdef WB_BYPASS_EN
      if (com && dm != 4'hF && s == dm) return valM;
      if (com && de != 4'hF && s == de) return valE;
`else
      if (com && 1'b0) return 64'd0;
`endif
      return m_regs[s];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
      m_stat = 0;
      m_ret  = 32'd0;
   endtask

   task automatic model_commit();
      logic [3:0] de, dm;
      if (!(wb_en && m_stat == 0)) return;
      if (icode > 11) begin
         m_stat = 2;
         return;
      end
      m_ret = m_ret + 32'd1;
      de = ref_dstE(icode, cnd, rB);
      dm = ref_dstM(icode, rA);
      if (de != 4'hF) m_regs[de] = valE;
      if (dm != 4'hF) m_regs[dm] = valM;
      if (icode == 0) m_stat = 1;
   endtask

   task automatic drive(input logic w, input logic [3:0] ic,
                        input logic c, input logic [3:0] a,
                        input logic [3:0] b, input logic [63:0] ve,
                        input logic [63:0] vm, input logic [3:0] sa,
                        input logic [3:0] sb);
      wb_en = w; icode = ic; cnd = c; rA = a; rB = b;
      valE = ve; valM = vm; srcA = sa; srcB = sb;
      #1;
   endtask

   task automatic pre_check();
      chk("dstE", 64'(dstE), 64'(ref_dstE(icode, cnd, rB)));
      chk("dstM", 64'(dstM), 64'(ref_dstM(icode, rA)));
      chk("valA", valA, ref_read(srcA));
      chk("valB", valB, ref_read(srcB));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_commit();
      chk("stat", 64'(stat), 64'(m_stat));
      chk("retired", 64'(retired), 64'(m_ret));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wb_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   typedef struct {
      logic [3:0] ic;
      logic       c;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] eE;
      logic [3:0] eM;
   } dvec_t;

   dvec_t tbl [12];

   initial begin
      nvec = 0;
      nerr = 0;
      rst = 1'b1;
      wb_en = 0; icode = 0; cnd = 0; rA = 4'hF; rB = 4'hF;
      valE = 0; valM = 0; srcA = 4'hF; srcB = 4'hF;
      model_reset();
      #12;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // reset state
      for (int i = 0; i < 15; i++) begin
         drive(0, 4'h1, 0, 4'hF, 4'hF, 0, 0, 4'(i), 4'hF);
         chk("rst_reg", valA, 64'd0);
      end
      chk("rst_stat", 64'(stat), 64'd0);
      chk("rst_ret", 64'(retired), 64'd0);

      // destination decode table (wb_en=0, so no state changes)
      tbl[0]  = '{4'h2, 1'b1, 4'h1, 4'h3, 4'h3, 4'hF};
      tbl[1]  = '{4'h2, 1'b0, 4'h1, 4'h3, 4'hF, 4'hF};
      tbl[2]  = '{4'h3, 1'b0, 4'hF, 4'h7, 4'h7, 4'hF};
      tbl[3]  = '{4'h6, 1'b0, 4'h2, 4'hE, 4'hE, 4'hF};
      tbl[4]  = '{4'h5, 1'b1, 4'h9, 4'h2, 4'hF, 4'h9};
      tbl[5]  = '{4'h8, 1'b0, 4'hF, 4'hF, 4'h4, 4'hF};
      tbl[6]  = '{4'h9, 1'b0, 4'hF, 4'hF, 4'h4, 4'hF};
      tbl[7]  = '{4'hA, 1'b0, 4'h6, 4'hF, 4'h4, 4'hF};
      tbl[8]  = '{4'hB, 1'b0, 4'hA, 4'hF, 4'h4, 4'hA};
      tbl[9]  = '{4'h4, 1'b1, 4'h1, 4'h2, 4'hF, 4'hF};
      tbl[10] = '{4'h0, 1'b1, 4'h1, 4'h2, 4'hF, 4'hF};
      tbl[11] = '{4'hC, 1'b1, 4'h1, 4'h2, 4'hF, 4'hF};
      for (int i = 0; i < 12; i++) begin
         drive(0, tbl[i].ic, tbl[i].c, tbl[i].a, tbl[i].b,
               64'h1, 64'h2, 4'hF, 4'hF);
         chk("tbl_dstE", 64'(dstE), 64'(tbl[i].eE));
         chk("tbl_dstM", 64'(dstM), 64'(tbl[i].eM));
      end
      tick();

      // irmovq then read
      drive(1, 4'h3, 0, 4'hF, 4'h2, 64'h1234, 0, 4'hF, 4'hF);
      tick();
      drive(0, 4'h1, 0, 4'hF, 4'hF, 0, 0, 4'h2, 4'hF);
      chk("irmov_rd", valA, 64'h1234);
      chk("irmov_ret", 64'(retired), 64'd1);

      // cmov not taken
      drive(1, 4'h2, 0, 4'h1, 4'h3, 64'hFF, 0, 4'hF, 4'hF);
      chk("cmov_dstE", 64'(dstE), 64'hF);
      tick();
      drive(0, 4'h1, 0, 4'hF, 4'hF, 0, 0, 4'h3, 4'hF);
      chk("cmov_reg3", valA, 64'd0);

      // popq %rsp: memory value wins
      drive(1, 4'hB, 0, 4'h4, 4'hF, 64'h100, 64'hABC, 4'hF, 4'hF);
      tick();
      drive(0, 4'h1, 0, 4'hF, 4'hF, 0, 0, 4'h4, 4'hF);
      chk("popq_rsp", valA, 64'hABC);

      // same-cycle read of a register being written
      drive(1, 4'h3, 0, 4'hF, 4'h5, 64'h55, 0, 4'hF, 4'hF);
      tick();
      drive(1, 4'h6, 0, 4'h1, 4'h5, 64'h77, 0, 4'hF, 4'h5);
`ifdef WB_BYPASS_EN
      chk("bypass_pre", valB, 64'h77);
`else
      chk("bypass_pre", valB, 64'h55);
`endif
      tick();
      drive(0, 4'h1, 0, 4'hF, 4'hF, 0, 0, 4'hF, 4'h5);
      chk("bypass_post", valB, 64'h77);

      // async reset clears immediately and drops the pending write
      drive(1, 4'h3, 0, 4'hF, 4'h6, 64'h99, 0, 4'h5, 4'hF);
      rst = 1'b1;
      #1;
      chk("arst_clear", valA, 64'd0);
      chk("arst_ret", 64'(retired), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      drive(0, 4'h1, 0, 4'hF, 4'hF, 0, 0, 4'h6, 4'hF);
      chk("arst_lost", valA, 64'd0);

      // halt then write
      drive(1, 4'h0, 0, 4'hF, 4'hF, 0, 0, 4'hF, 4'hF);
      tick();
      chk("halt_stat", 64'(stat), 64'd1);
      chk("halt_ret", 64'(retired), 64'd1);
      drive(1, 4'h3, 0, 4'hF, 4'h1, 64'd5, 0, 4'hF, 4'hF);
      tick();
      drive(0, 4'h1, 0, 4'hF, 4'hF, 0, 0, 4'h1, 4'hF);
      chk("halt_nowr", valA, 64'd0);
      chk("halt_frz", 64'(retired), 64'd1);

      // illegal icode from reset
      do_reset();
      drive(1, 4'hC, 1, 4'h1, 4'h1, 64'h11, 64'h22, 4'hF, 4'hF);
      tick();
      chk("ins_stat", 64'(stat), 64'd2);
      chk("ins_ret", 64'(retired), 64'd0);
      drive(0, 4'h1, 0, 4'hF, 4'hF, 0, 0, 4'h1, 4'h4);
      chk("ins_nowrA", valA, 64'd0);
      chk("ins_nowrB", valB, 64'd0);

      // randomized traffic with periodic resets
      do_reset();
      for (int n = 0; n < 600; n++) begin
         logic [3:0] ic;
         int r;
         if (n % 50 == 49) do_reset();
         r = int'($urandom_range(0, 99));
         if (r < 2)      ic = 4'h0;
         else if (r < 4) ic = 4'($urandom_range(12, 15));
         else            ic = 4'($urandom_range(1, 11));
         drive(1'($urandom_range(0, 3) != 0), ic,
               1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               {$urandom, $urandom}, {$urandom, $urandom},
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         pre_check();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Y86-64 SEQ write-back stage plus architectural register file. It is the writer side of the register-file interface that the decode stage reads.
- Derives dstE/dstM from icode, cnd, rA and rB, then commits valE/valM into 15 x 64-bit registers on the clock edge.
- Serves combinational read ports srcA/srcB to decode.
- Tracks processor status and a retired-instruction count.

Parameters:
- XLEN, 64, register/data width
- NREG, 15, number of architectural registers; index 0xF means "none"
- RSP_IDX, 4, index of %rsp
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  input  1  system clock; all state updates on posedge
- rst  input  1  asynchronous active-high reset
- wb_en  input  1  current instruction valid for commit this cycle
- icode  input  4  instruction code of the committing instruction
- cnd  input  1  condition result from execute (used by cmovXX)
- rA  input  4  rA field of the committing instruction
- rB  input  4  rB field of the committing instruction
- valE  input  XLEN  ALU result
- valM  input  XLEN  memory read data
- srcA  input  4  decode read address A
- srcB  input  4  decode read address B
- valA  output  XLEN  register[srcA]; 0 when srcA==0xF
- valB  output  XLEN  register[srcB]; 0 when srcB==0xF
- dstE  output  4  combinational E-destination (0xF = none)
- dstM  output  4  combinational M-destination (0xF = none)
- stat  output  2  0=AOK, 1=HLT, 2=INS
- retired  output  CNT_W  count of committed instructions

Behaviour:
- Reset (async, immediate):
  - all 15 registers = 0
  - stat = AOK
  - retired = 0
- dstE (combinational):
  - icode 2 (rrmovq/cmovXX): rB if cnd=1, else 0xF
  - icode 3 and 6: rB
  - icode 8, 9, 10, 11: RSP_IDX
  - all other icodes: 0xF
- dstM (combinational):
  - icode 5 and 11: rA
  - all other icodes: 0xF
- Commit: "commit" = wb_en=1 and stat==AOK.
  - At posedge with commit, reg[dstE] <= valE if dstE != 0xF.
  - At the same edge, reg[dstM] <= valM if dstM != 0xF.
- Collision: if dstE==dstM (popq %rsp), valM wins.
- Illegal icode (>11) on a committing cycle:
  - no register write
  - stat <= INS
- icode 0 (halt) on a committing cycle:
  - no register write
  - stat <= HLT
  - retired still increments
- Once stat != AOK:
  - all writes and counter updates are frozen until rst
  - reads remain functional
- retired: +1 on each commit with a legal icode; wraps modulo 2^CNT_W.
- Reads: purely combinational from current register contents. Without the optional feature, a same-cycle write is visible only after the edge (one-cycle write-to-read latency).
- wb_en=0: no state change; dstE/dstM still reflect their inputs.
- Reset asserted mid-cycle: registers clear immediately; a write pending at that cycle is lost.

Optional Feature:
- Macro: WB_BYPASS_EN
- Defined: read ports forward in-flight write data.
  - If commit and srcX==dstM (!=0xF), valX = valM.
  - Else if commit and srcX==dstE (!=0xF), valX = valE.
  - Otherwise valX = register value.
  - Read-after-write latency becomes 0 cycles.
- Undefined: no forwarding; valA/valB always show pre-edge register contents.

Test Plan:
- Reset: rst pulse; read all srcA=0..14 → every valA=0, stat=0, retired=0.
- irmovq: icode=3, rB=2, valE=0x1234, wb_en=1; read srcA=2 the next cycle → valA=0x1234, retired=1.
- cmov not taken: icode=2, cnd=0, rB=3, valE=0xFF → dstE=0xF, reg3 unchanged.
- popq %rsp: icode=11, rA=4, valE=0x100, valM=0xABC → reg4=0xABC after the edge.
- Halt then write:
  - icode=0 commits → stat=1, retired incremented.
  - Following irmovq rB=1, valE=5 → reg1 unchanged, retired frozen.
  - Illegal icode=12 from reset → stat=2, no write.
- Bypass (WB_BYPASS_EN defined): icode=6, rB=5, valE=0x77 with srcB=5 in the same cycle → valB=0x77 before the edge. Without the macro, valB=old value.
